// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 integer-core definitions used by the register file and its read
// ports: architectural width, register count, index width and the x0 index.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the integer register file. Resolves x0 to
// zero, optionally forwards the in-flight write data, otherwise returns the
// stored register.
//
// Build option: REGFILE_BYPASS_EN -- when defined, a read whose index matches
// an enabled, non-x0 write in the same cycle returns the write data before the
// clock edge. When undefined, only stored contents are returned.
//
// Ports:
//   idx      in   read register index
//   regs     in   storage view, entry 0 is constant zero
//   rst      in   active-high reset; forces the read data to zero
//   reg_wen  in   write enable of the write port
//   rd       in   write register index
//   rdv      in   write data
//   data     out  read data
// -----------------------------------------------------------------------------
module regfile_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic              rst,
  input  logic              reg_wen,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rdv,
  output logic [DATA_W-1:0] data
);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;

  // rd == 0 is excluded so a discarded x0 write can never leak onto a port.
  assign bypass_hit = reg_wen && !rst && (rd != '0) && (rd == idx);

  always_comb begin
    data = '0;
    if (rst || idx == '0) begin
      data = '0;
    end else if (bypass_hit) begin
      data = rdv;
    end else begin
      data = regs[idx];
    end
  end
`else
  // Write-side inputs are only needed for forwarding.
  logic unused_wr;
  assign unused_wr = ^{reg_wen, rd, rdv};

  always_comb begin
    data = '0;
    if (rst || idx == '0) begin
      data = '0;
    end else begin
      data = regs[idx];
    end
  end
`endif

endmodule

// File: rtl/riscv_register_file.sv
// -----------------------------------------------------------------------------
// riscv_register_file
// RV32 integer register file: NUM_REGS x DATA_W registers, two combinational
// read ports and one synchronous write port. x0 has no storage and reads zero.
//
// Build option: REGFILE_BYPASS_EN -- write-through forwarding on both read
// ports (see regfile_read_port).
//
// Ports:
//   clk       in   clock; writes on rising edge
//   rst       in   asynchronous active-high reset, clears all registers
//   rs1       in   read port 1 index
//   rs2       in   read port 2 index
//   rd        in   write index (writes to x0 are dropped)
//   rdv       in   write data
//   reg_wen   in   write enable
//   rs1_data  out  read port 1 data
//   rs2_data  out  read port 2 data
// -----------------------------------------------------------------------------
module riscv_register_file #(
  parameter int DATA_W   = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rdv,
  input  logic              reg_wen,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  import riscv_pkg::*;

  // Storage exists only for x1..x(NUM_REGS-1).
  logic [DATA_W-1:0] regs_q    [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_view [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_wen) begin
      // Index 0 never matches here, so x0 writes fall away.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd == ADDR_W'(i)) begin
          regs_q[i] <= rdv;
        end
      end
    end
  end

  always_comb begin
    regs_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_view[i] = regs_q[i];
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_REGS)
  ) u_rd_port1 (
    .idx     (rs1),
    .regs    (regs_view),
    .rst     (rst),
    .reg_wen (reg_wen),
    .rd      (rd),
    .rdv     (rdv),
    .data    (rs1_data)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .DEPTH  (NUM_REGS)
  ) u_rd_port2 (
    .idx     (rs2),
    .regs    (regs_view),
    .rst     (rst),
    .reg_wen (reg_wen),
    .rd      (rd),
    .rdv     (rdv),
    .data    (rs2_data)
  );

endmodule

// File: tb/tb_riscv_register_file.sv
module tb_riscv_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rdv;
  logic        reg_wen;
  logic [31:0] rs1_data, rs2_data;

  riscv_register_file dut (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .rdv      (rdv),
    .reg_wen  (reg_wen),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  // Architectural view: 32 registers, x0 never written.
  logic [31:0] model [32];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (rst) return 32'h0;
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (reg_wen && rd == idx) return rdv;
`endif
    return model[idx];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_rs1"}, rs1_data, expect_read(rs1));
    check({tag, "_rs2"}, rs2_data, expect_read(rs2));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One rising edge; the model captures what the edge should store.
  task automatic tick();
    @(posedge clk);
    if (!rst && reg_wen && rd != 5'd0) model[rd] = rdv;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0; rdv = '0; reg_wen = 1'b0;
    clear_model();
    #2 rst = 1'b1;
    // Writes and bypass are ignored while in reset.
    rd = 5'd3; rdv = 32'hA5A5A5A5; reg_wen = 1'b1; rs1 = 5'd3; rs2 = 5'd3;
    #1 check("in_reset_bypass", rs1_data, 32'h0);
    tick();
    tick();
    reg_wen = 1'b0;
    rst = 1'b0;
    #1;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i + 1);
      #1;
      check("reset_rs1", rs1_data, 32'h0);
      check("reset_rs2", rs2_data, 32'h0);
    end

    // Basic write/read.
    rd = 5'd5; rdv = 32'hDEAEEFFA; reg_wen = 1'b1;
    tick();
    reg_wen = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
    #1 check("wr_x5_rs1", rs1_data, 32'hDEAEEFFA);
    rs2 = 5'd5;
    #1 check("wr_x5_rs2", rs2_data, 32'hDEAEEFFA);

    // x0 protection, before and after the edge.
    rd = 5'd0; rdv = 32'h12345678; reg_wen = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    #1 check("x0_pre_rs1", rs1_data, 32'h0);
    check("x0_pre_rs2", rs2_data, 32'h0);
    tick();
    reg_wen = 1'b0;
    #1 check("x0_post_rs1", rs1_data, 32'h0);
    check("x0_post_rs2", rs2_data, 32'h0);

    // Same-cycle write/read of x10.
    rd = 5'd10; rs1 = 5'd10; rs2 = 5'd10; rdv = 32'hCAFECAFE; reg_wen = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_pre", rs1_data, 32'hCAFECAFE);
`else
    check("bypass_pre", rs1_data, 32'h0);
`endif
    check_reads("bypass_pre_model");
    tick();
    reg_wen = 1'b0;
    #1 check("bypass_post", rs1_data, 32'hCAFECAFE);

    // Write-enable gating.
    rd = 5'd7; rdv = 32'h11111111; reg_wen = 1'b0; rs1 = 5'd7;
    tick();
    check("wen_gate_x7", rs1_data, 32'h0);

    // Async reset between edges.
    rd = 5'd5; rdv = 32'h0BADF00D; reg_wen = 1'b1;
    tick();
    reg_wen = 1'b0; rs1 = 5'd5;
    #1 check("pre_async_x5", rs1_data, 32'h0BADF00D);
    #1 rst = 1'b1; clear_model();
    #1 check("async_rst_x5", rs1_data, 32'h0);
    rst = 1'b0;
    #1 check("after_rst_x5", rs1_data, 32'h0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      rs1     = 5'($urandom_range(0, 31));
      rs2     = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      rd      = ($urandom_range(0, 2) == 0) ? rs1 : 5'($urandom_range(0, 31));
      rdv     = $urandom;
      reg_wen = 1'($urandom_range(0, 1));
      #1 check_reads("rand");
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; clear_model();
        #1 check_reads("rand_rst");
        rst = 1'b0;
        #1 check_reads("rand_rst_rel");
      end
      tick();
    end

    reg_wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1 check_reads("final_sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
